syn_fifo_ext_module: RTL

SYN_FIFO_EXT_MODULE -- requirements
Module: syn_fifo_ext_module

---
 rtl/syn_fifo_pkg.sv | 18 +
 rtl/dual_ram_module.sv | 34 +++
 rtl/syn_fifo_ext_module.sv | 133 +++++++++++++
 3 files changed

// File: rtl/syn_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package syn_fifo_pkg;

    localparam int unsigned C_DATA_WIDTH    = 8;
    localparam int unsigned C_ADDR_DEPTH    = 16;
    localparam int unsigned C_AEMPTY_THRESH = 2;

    // Ceiling log2; returns 0 for a value of 1.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dual_ram_module.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
module dual_ram_module
    import syn_fifo_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned P_ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [P_ADDR_WIDTH-1:0] i_waddr,
    input  logic [P_DATA_WIDTH-1:0] i_wdata,
    input  logic                    i_re,
    input  logic [P_ADDR_WIDTH-1:0] i_raddr,
    output logic [P_DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << P_ADDR_WIDTH;

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Read data is held until the next read enable.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/syn_fifo_ext_module.sv
// Synchronous FIFO with almost-full/empty flags and overflow/underflow pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is standard reads.
module syn_fifo_ext_module
    import syn_fifo_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH    = C_DATA_WIDTH,
    parameter int unsigned P_ADDR_DEPTH    = C_ADDR_DEPTH,
    parameter int unsigned P_AFULL_THRESH  = P_ADDR_DEPTH - 2,
    parameter int unsigned P_AEMPTY_THRESH = C_AEMPTY_THRESH
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_wr_en,
    input  logic [P_DATA_WIDTH-1:0]          i_wdata,
    output logic                             o_wfull,
    output logic                             o_afull,
    output logic                             o_overflow,
    input  logic                             i_rd_en,
    output logic [P_DATA_WIDTH-1:0]          o_rdata,
    output logic                             o_rvalid,
    output logic                             o_rempty,
    output logic                             o_aempty,
    output logic                             o_underflow,
    output logic [clogb2(P_ADDR_DEPTH):0]    o_count
);

    localparam int unsigned AW = clogb2(P_ADDR_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    ram_re;
    logic [P_DATA_WIDTH-1:0] ram_dout;

    assign o_wfull  = (o_count == PW'(P_ADDR_DEPTH));
    assign o_afull  = (o_count >= PW'(P_AFULL_THRESH));
    assign o_aempty = (o_count <= PW'(P_AEMPTY_THRESH));
    assign wr_acc   = i_wr_en && !o_wfull;
    assign rd_acc   = i_rd_en && !o_rempty;

    dual_ram_module #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_acc),
        .i_waddr (wr_ptr[AW-1:0]),
        .i_wdata (i_wdata),
        .i_re    (ram_re),
        .i_raddr (rd_ptr[AW-1:0]),
        .o_rdata (ram_dout)
    );

    // Pointers, occupancy and error pulses; rejected requests change nothing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wr_en && o_wfull;
            o_underflow <= i_rd_en && o_rempty;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr_acc && !rd_acc) begin
                o_count <= o_count + PW'(1);
            end else if (rd_acc && !wr_acc) begin
                o_count <= o_count - PW'(1);
            end
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    // Two-stage head: RAM read register (dout_valid) feeding the visible head register.
    logic head_valid;
    logic dout_valid;
    logic consume;

    assign o_rempty = !head_valid;
    assign o_rvalid = head_valid;
    assign consume  = dout_valid && (!head_valid || i_rd_en);
    assign ram_re   = (wr_ptr != rd_ptr) && (!dout_valid || consume);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_valid <= 1'b0;
            dout_valid <= 1'b0;
            o_rdata    <= '0;
        end else begin
            if (consume) begin
                o_rdata    <= ram_dout;
                head_valid <= 1'b1;
            end else if (rd_acc) begin
                head_valid <= 1'b0;
            end
            if (ram_re) begin
                dout_valid <= 1'b1;
            end else if (consume) begin
                dout_valid <= 1'b0;
            end
        end
    end
`else
    // Equal pointers (including the wrap bit) can only mean empty.
    logic rd_pend;

    assign o_rempty = (wr_ptr == rd_ptr);
    assign ram_re   = rd_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_pend  <= 1'b0;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
        end else begin
            rd_pend  <= ram_re;
            o_rvalid <= rd_pend;
            if (rd_pend) begin
                o_rdata <= ram_dout;
            end
        end
    end
`endif

endmodule
